// File: rtl/ex_mem_reg.sv
// ex_mem_reg: pipeline register between the 16-bit ALU (execute) and the
// memory/writeback stage. It qualifies the write/read enables, generates the
// R0 write for multiply/divide, squashes on flush, holds on stall, and keeps a
// sticky overflow exception together with the PC of the first faulting
// instruction.
//
// Handshake: stall is a level "downstream not ready". While stall=1 every
// register holds (exception state included) and the upstream stage is
// expected to hold its inputs; nothing is consumed until stall drops.
// exc_ovf is the registered decode of the exception FSM state (NORMAL/EXC),
// so it doubles as the observable state of that FSM.
module ex_mem_reg #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_pc,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] alu_r0,
    input  logic          alu_ovf,
    input  logic [3:0]    alu_ctrl,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_reg_write,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic [DW-1:0] ex_store_data,
    input  logic          stall,
    input  logic          flush,
    input  logic          exc_clear,
    output logic          mem_valid,
    output logic [DW-1:0] mem_result,
    output logic [DW-1:0] mem_r0,
    output logic [RW-1:0] mem_rd,
    output logic          mem_reg_write,
    output logic          mem_r0_write,
    output logic          mem_mem_read,
    output logic          mem_mem_write,
    output logic [DW-1:0] mem_store_data,
    output logic          exc_ovf,
    output logic [DW-1:0] epc
);

    typedef enum logic {
        EXC_NORMAL = 1'b0,
        EXC_ACTIVE = 1'b1
    } exc_state_e;

    localparam logic [3:0] OP_MUL = 4'h4;
    localparam logic [3:0] OP_DIV = 4'h8;

    logic          valid_q,      valid_d;
    logic [DW-1:0] result_q,     result_d;
    logic [DW-1:0] r0_q,         r0_d;
    logic [RW-1:0] rd_q,         rd_d;
    logic          reg_write_q,  reg_write_d;
    logic          r0_write_q,   r0_write_d;
    logic          mem_read_q,   mem_read_d;
    logic          mem_write_q,  mem_write_d;
    logic [DW-1:0] store_data_q, store_data_d;
    exc_state_e    exc_state_q,  exc_state_d;
    logic [DW-1:0] epc_q,        epc_d;

    logic kill;
    logic is_muldiv;
    logic rd_write_ok;

    assign kill        = ex_valid & alu_ovf;
    assign is_muldiv   = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_DIV);
    assign rd_write_ok = ex_valid & ex_reg_write & ~kill;

    // Next-state: hold on stall, squash on flush, otherwise load and qualify.
    always_comb begin
        valid_d      = valid_q;
        result_d     = result_q;
        r0_d         = r0_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        r0_write_d   = r0_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        store_data_d = store_data_q;
        exc_state_d  = exc_state_q;
        epc_d        = epc_q;

        if (!stall) begin
            if (flush) begin
                valid_d      = 1'b0;
                result_d     = '0;
                r0_d         = '0;
                rd_d         = '0;
                reg_write_d  = 1'b0;
                r0_write_d   = 1'b0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                store_data_d = '0;
            end else begin
                // A killed instruction keeps valid=1 so the bubble is visible.
                valid_d      = ex_valid;
                result_d     = alu_out;
                r0_d         = alu_r0;
                rd_d         = ex_rd;
                reg_write_d  = rd_write_ok;
                r0_write_d   = rd_write_ok & is_muldiv;
                mem_read_d   = ex_valid & ex_mem_read & ~kill;
                mem_write_d  = ex_valid & ex_mem_write & ~kill;
                store_data_d = ex_store_data;
            end

            // First fault wins, except that a clear on the same edge as a new
            // fault lets the new fault take over the recorded PC.
            if (!flush && kill) begin
                exc_state_d = EXC_ACTIVE;
                if (exc_state_q == EXC_NORMAL || exc_clear) begin
                    epc_d = ex_pc;
                end
            end else if (exc_clear) begin
                exc_state_d = EXC_NORMAL;
            end
        end
    end

    // State registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            result_q     <= '0;
            r0_q         <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            r0_write_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            store_data_q <= '0;
            exc_state_q  <= EXC_NORMAL;
            epc_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            result_q     <= result_d;
            r0_q         <= r0_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            r0_write_q   <= r0_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            store_data_q <= store_data_d;
            exc_state_q  <= exc_state_d;
            epc_q        <= epc_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_result     = result_q;
    assign mem_r0         = r0_q;
    assign mem_rd         = rd_q;
    assign mem_reg_write  = reg_write_q;
    assign mem_r0_write   = r0_write_q;
    assign mem_mem_read   = mem_read_q;
    assign mem_mem_write  = mem_write_q;
    assign mem_store_data = store_data_q;
    assign exc_ovf        = (exc_state_q == EXC_ACTIVE);
    assign epc            = epc_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios followed by randomized traffic,
// all outputs compared against a behavioural model of the pipeline register.
module tb_ex_mem_reg;

  localparam int DW = 16;
  localparam int RW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ex_valid;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] alu_out;
  logic [DW-1:0] alu_r0;
  logic          alu_ovf;
  logic [3:0]    alu_ctrl;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic [DW-1:0] ex_store_data;
  logic          stall;
  logic          flush;
  logic          exc_clear;
  logic          mem_valid;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] mem_r0;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_write;
  logic          mem_r0_write;
  logic          mem_mem_read;
  logic          mem_mem_write;
  logic [DW-1:0] mem_store_data;
  logic          exc_ovf;
  logic [DW-1:0] epc;

  ex_mem_reg #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .alu_out(alu_out), .alu_r0(alu_r0), .alu_ovf(alu_ovf), .alu_ctrl(alu_ctrl),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
    .stall(stall), .flush(flush), .exc_clear(exc_clear),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_r0(mem_r0),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_r0_write(mem_r0_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_store_data(mem_store_data), .exc_ovf(exc_ovf), .epc(epc)
  );

  // ---------------- reference model ----------------
  // Contents of the stage as seen after each edge.
  typedef struct {
    logic          valid;
    logic [DW-1:0] result;
    logic [DW-1:0] r0;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          r0_write;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] store_data;
    logic          exc;
    logic [DW-1:0] epc;
  } stage_t;

  stage_t m;

  function automatic stage_t zero_stage();
    stage_t s;
    s.valid = 0; s.result = '0; s.r0 = '0; s.rd = '0; s.reg_write = 0;
    s.r0_write = 0; s.mem_read = 0; s.mem_write = 0; s.store_data = '0;
    s.exc = 0; s.epc = '0;
    return s;
  endfunction

  // Apply one rising edge to the model using the currently driven inputs.
  task automatic model_edge();
    bit faulting;
    bit writes_rd;
    stage_t keep;
    if (rst) begin
      m = zero_stage();
    end else if (!stall) begin
      keep = m;
      faulting = !flush && ex_valid && alu_ovf;
      if (flush) begin
        m = zero_stage();
        m.exc = keep.exc;
        m.epc = keep.epc;
      end else begin
        writes_rd    = ex_valid && ex_reg_write && !alu_ovf;
        m.valid      = ex_valid;
        m.result     = alu_out;
        m.r0         = alu_r0;
        m.rd         = ex_rd;
        m.reg_write  = writes_rd;
        m.r0_write   = writes_rd && (alu_ctrl == 4'd4 || alu_ctrl == 4'd8);
        m.mem_read   = ex_valid && ex_mem_read && !alu_ovf;
        m.mem_write  = ex_valid && ex_mem_write && !alu_ovf;
        m.store_data = ex_store_data;
      end
      if (faulting) begin
        if (!keep.exc || exc_clear) m.epc = ex_pc;
        m.exc = 1;
      end else if (exc_clear) begin
        m.exc = 0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},      32'(mem_valid),      32'(m.valid));
    check({tag, ".result"},     32'(mem_result),     32'(m.result));
    check({tag, ".r0"},         32'(mem_r0),         32'(m.r0));
    check({tag, ".rd"},         32'(mem_rd),         32'(m.rd));
    check({tag, ".reg_write"},  32'(mem_reg_write),  32'(m.reg_write));
    check({tag, ".r0_write"},   32'(mem_r0_write),   32'(m.r0_write));
    check({tag, ".mem_read"},   32'(mem_mem_read),   32'(m.mem_read));
    check({tag, ".mem_write"},  32'(mem_mem_write),  32'(m.mem_write));
    check({tag, ".store_data"}, 32'(mem_store_data), 32'(m.store_data));
    check({tag, ".exc_ovf"},    32'(exc_ovf),        32'(m.exc));
    check({tag, ".epc"},        32'(epc),            32'(m.epc));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rst = 0; ex_valid = 0; ex_pc = '0; alu_out = '0; alu_r0 = '0; alu_ovf = 0;
    alu_ctrl = 4'h1; ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0;
    ex_mem_write = 0; ex_store_data = '0; stall = 0; flush = 0; exc_clear = 0;
  endtask

  task automatic alu_op(input logic [3:0] ctrl, input logic [DW-1:0] res,
                        input logic [DW-1:0] r0, input logic ovf,
                        input logic [DW-1:0] pc, input logic [RW-1:0] rd);
    ex_valid = 1; alu_ctrl = ctrl; alu_out = res; alu_r0 = r0; alu_ovf = ovf;
    ex_pc = pc; ex_rd = rd; ex_reg_write = 1; ex_mem_read = 0; ex_mem_write = 0;
  endtask

  // One edge: update model, then sample DUT 1 time unit after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  function automatic logic [3:0] rand_ctrl();
    logic [3:0] ops [7];
    ops = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF};
    return ops[$urandom_range(0, 6)];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    m = zero_stage();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    step("reset");
    check("reset.valid_const", 32'(mem_valid), 32'd0);
    check("reset.epc_const", 32'(epc), 32'd0);
    rst = 0;

    // Add pass-through.
    alu_op(4'h1, 16'h0005, 16'h0000, 0, 16'h0010, 4'd3);
    step("add");
    check("add.result_const", 32'(mem_result), 32'h5);
    check("add.rd_const", 32'(mem_rd), 32'd3);
    check("add.reg_write_const", 32'(mem_reg_write), 32'd1);
    check("add.r0_write_const", 32'(mem_r0_write), 32'd0);

    // Multiply and divide write R0.
    alu_op(4'h4, 16'h0000, 16'h0001, 0, 16'h0012, 4'd4);
    step("mul");
    check("mul.r0_write_const", 32'(mem_r0_write), 32'd1);
    check("mul.r0_const", 32'(mem_r0), 32'h1);
    alu_op(4'h8, 16'h0003, 16'h0002, 0, 16'h0014, 4'd5);
    step("div");
    check("div.r0_write_const", 32'(mem_r0_write), 32'd1);
    check("div.r0_const", 32'(mem_r0), 32'h2);

    // Overflow kill, first fault wins, then clear.
    alu_op(4'h1, 16'h8000, 16'h0000, 1, 16'h0040, 4'd6);
    step("ovf1");
    check("ovf1.valid_const", 32'(mem_valid), 32'd1);
    check("ovf1.reg_write_const", 32'(mem_reg_write), 32'd0);
    check("ovf1.exc_const", 32'(exc_ovf), 32'd1);
    check("ovf1.epc_const", 32'(epc), 32'h40);
    alu_op(4'h2, 16'h7FFF, 16'h0000, 1, 16'h0044, 4'd7);
    step("ovf2");
    check("ovf2.epc_const", 32'(epc), 32'h40);
    alu_op(4'h1, 16'h0001, 16'h0000, 0, 16'h0046, 4'd1);
    exc_clear = 1;
    step("clear");
    check("clear.exc_const", 32'(exc_ovf), 32'd0);
    exc_clear = 0;

    // Stall beats flush; then flush squashes.
    alu_op(4'h1, 16'h1234, 16'h0000, 0, 16'h0048, 4'd2);
    ex_mem_write = 1;
    step("load1234");
    stall = 1; flush = 1; alu_out = 16'hFFFF; alu_ovf = 1;
    for (int i = 0; i < 2; i++) begin
      step("stall_hold");
      check("stall.result_const", 32'(mem_result), 32'h1234);
      check("stall.valid_const", 32'(mem_valid), 32'd1);
      check("stall.exc_const", 32'(exc_ovf), 32'd0);
    end
    stall = 0;
    step("flush");
    check("flush.valid_const", 32'(mem_valid), 32'd0);
    check("flush.enables_const",
          32'({mem_reg_write, mem_r0_write, mem_mem_read, mem_mem_write}), 32'd0);
    flush = 0;

    // Clear together with a new fault: new fault wins.
    alu_op(4'h1, 16'h8000, 16'h0000, 1, 16'h0040, 4'd6);
    step("ovf40");
    alu_op(4'h2, 16'h8001, 16'h0000, 1, 16'h0050, 4'd6);
    exc_clear = 1;
    step("clear_vs_fault");
    check("cvf.exc_const", 32'(exc_ovf), 32'd1);
    check("cvf.epc_const", 32'(epc), 32'h50);
    exc_clear = 0;

    // Reset overrides stall.
    rst = 1; stall = 1;
    step("mid_reset");
    check("mid_reset.exc_const", 32'(exc_ovf), 32'd0);
    check("mid_reset.result_const", 32'(mem_result), 32'd0);
    rst = 0; stall = 0;

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 99) < 2);
      ex_valid      = ($urandom_range(0, 99) < 80);
      ex_pc         = DW'($urandom);
      alu_out       = DW'($urandom);
      alu_r0        = DW'($urandom);
      alu_ovf       = ($urandom_range(0, 99) < 20);
      alu_ctrl      = rand_ctrl();
      ex_rd         = RW'($urandom);
      ex_reg_write  = ($urandom_range(0, 99) < 70);
      ex_mem_read   = ($urandom_range(0, 99) < 30);
      ex_mem_write  = ($urandom_range(0, 99) < 30);
      ex_store_data = DW'($urandom);
      stall         = ($urandom_range(0, 99) < 25);
      flush         = ($urandom_range(0, 99) < 15);
      exc_clear     = ($urandom_range(0, 99) < 15);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
